// File: rtl/aes_pkg.sv
// Shared AES control types: sequencer state encoding, round-count constants and
// the registered control-strobe bundle driven into the round datapath.
package aes_pkg;

    localparam int unsigned AES128_NR = 10;
    localparam int unsigned AES192_NR = 12;
    localparam int unsigned AES256_NR = 14;
    localparam int unsigned ROUND_W   = 4;
    localparam int unsigned STAGE_W   = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT_ARK = 3'd1,
        SUB      = 3'd2,
        SHIFT    = 3'd3,
        MIX      = 3'd4,
        ARK      = 3'd5,
        DONE     = 3'd6
    } aes_state_e;

    typedef struct packed {
        logic load_state;
        logic en_add_key;
        logic en_sub_byte;
        logic en_shift_rows;
        logic en_mix_col;
        logic mix_bypass;
    } aes_ctrl_t;

endpackage

// File: rtl/aes_stage_timer.sv
// Per-stage cycle counter: restarts on load or after the last cycle of a stage
// and flags the first and last cycle of the current stage.
module aes_stage_timer
    import aes_pkg::*;
#(
    parameter int unsigned STAGE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_first_cycle_c,
    output logic o_last_cycle_c
);

    logic [STAGE_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load || o_last_cycle_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + STAGE_W'(1);
        end
    end

    assign o_first_cycle_c = (r_cnt == '0);
    assign o_last_cycle_c  = (r_cnt == STAGE_W'(STAGE_CYCLES - 1));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer with start/busy/done handshake.
// Optional abort input is enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR           = AES128_NR,
    parameter int unsigned STAGE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic [ROUND_W-1:0] round_num,
    output logic               load_state,
    output logic               en_add_key,
    output logic               en_sub_byte,
    output logic               en_shift_rows,
    output logic               en_mix_col,
    output logic               mix_bypass
);

    aes_state_e         r_state;
    aes_state_e         w_state_nxt;
    logic [ROUND_W-1:0] r_round;
    logic [ROUND_W-1:0] w_round_nxt;
    aes_ctrl_t          r_ctrl;
    aes_ctrl_t          w_ctrl_nxt;
    logic               r_busy;
    logic               r_done;
    logic               w_timed;
    logic               w_first_cycle_c;
    logic               w_last_cycle_c;

    // Counter only runs inside the timed stages; IDLE and DONE hold it at zero.
    assign w_timed = (r_state != IDLE) && (r_state != DONE);

    aes_stage_timer #(
        .STAGE_CYCLES (STAGE_CYCLES)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .i_load          (!w_timed),
        .o_first_cycle_c (w_first_cycle_c),
        .o_last_cycle_c  (w_last_cycle_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_round <= '0;
            r_ctrl  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_ctrl_nxt  = '0;
        case (r_state)
            IDLE:     if (start) w_state_nxt = INIT_ARK;
            INIT_ARK: if (w_last_cycle_c) begin
                          w_state_nxt = SUB;
                          w_round_nxt = r_round + ROUND_W'(1);
                      end
            SUB:      if (w_last_cycle_c) w_state_nxt = SHIFT;
            SHIFT:    if (w_last_cycle_c) w_state_nxt = MIX;
            MIX:      if (w_last_cycle_c) w_state_nxt = ARK;
            ARK:      if (w_last_cycle_c) begin
                          if (r_round < ROUND_W'(NR)) begin
                              w_state_nxt = SUB;
                              w_round_nxt = r_round + ROUND_W'(1);
                          end else begin
                              w_state_nxt = DONE;
                          end
                      end
            DONE:     begin
                          w_state_nxt = IDLE;
                          w_round_nxt = '0;
                      end
            default:  begin
                          w_state_nxt = IDLE;
                          w_round_nxt = '0;
                      end
        endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
        if (abort && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_round_nxt = '0;
        end
`endif
        // Strobes fire only on stage entry, i.e. the first cycle of the new state.
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                INIT_ARK: begin
                    w_ctrl_nxt.en_add_key = 1'b1;
                    w_ctrl_nxt.load_state = 1'b1;
                end
                SUB:      w_ctrl_nxt.en_sub_byte   = 1'b1;
                SHIFT:    w_ctrl_nxt.en_shift_rows = 1'b1;
                MIX:      if (w_round_nxt == ROUND_W'(NR)) w_ctrl_nxt.mix_bypass = 1'b1;
                          else                             w_ctrl_nxt.en_mix_col = 1'b1;
                ARK:      w_ctrl_nxt.en_add_key = 1'b1;
                default:  ;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign round_num     = r_round;
    assign load_state    = r_ctrl.load_state;
    assign en_add_key    = r_ctrl.en_add_key;
    assign en_sub_byte   = r_ctrl.en_sub_byte;
    assign en_shift_rows = r_ctrl.en_shift_rows;
    assign en_mix_col    = r_ctrl.en_mix_col;
    assign mix_bypass    = r_ctrl.mix_bypass;

`ifndef SYNTHESIS
    a_strobe_first: assert property (@(posedge clk) disable iff (rst)
        (en_add_key | en_sub_byte | en_shift_rows | en_mix_col | mix_bypass) |-> w_first_cycle_c);
    a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0({en_add_key, en_sub_byte, en_shift_rows, en_mix_col, mix_bypass}));
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: AES-128 single-cycle and AES-256 three-cycle
// stage instances; abort scenarios run when AES_ROUND_CTRL_ABORT_EN is defined.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b;
    logic       busy_a, done_a, load_a, add_a, sub_a, shift_a, mix_a, byp_a;
    logic       busy_b, done_b, load_b, add_b, sub_b, shift_b, mix_b, byp_b;
    logic [3:0] round_a, round_b;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic       abort_a, abort_b;
`endif

    int n_cmp, n_err, cyc, last_done_cyc, t0, nz;

    aes_round_ctrl #(.NR(10), .STAGE_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort(abort_a),
`endif
        .busy(busy_a), .done(done_a), .round_num(round_a), .load_state(load_a),
        .en_add_key(add_a), .en_sub_byte(sub_a), .en_shift_rows(shift_a),
        .en_mix_col(mix_a), .mix_bypass(byp_a)
    );

    aes_round_ctrl #(.NR(14), .STAGE_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort(abort_b),
`endif
        .busy(busy_b), .done(done_b), .round_num(round_b), .load_state(load_b),
        .en_add_key(add_b), .en_sub_byte(sub_b), .en_shift_rows(shift_b),
        .en_mix_col(mix_b), .mix_bypass(byp_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // {busy, done, round[3:0], load, add_key, sub, shift, mix, bypass}
    function automatic logic [11:0] obs(input int sel);
        if (sel == 0)
            return {busy_a, done_a, round_a, load_a, add_a, sub_a, shift_a, mix_a, byp_a};
        return {busy_b, done_b, round_b, load_b, add_b, sub_b, shift_b, mix_b, byp_b};
    endfunction

    // Expected outputs k cycles after the edge that accepted start.
    function automatic logic [11:0] exp_vec(input int nr, input int sc, input int k);
        int          len, j, s, rnd;
        logic [11:0] v;
        len = 1 + sc * (1 + 4 * nr);
        v   = '0;
        if (k >= 1 && k < len) begin
            v[11] = 1'b1;
            if (k <= sc) begin
                v[5] = (k == 1);
                v[4] = (k == 1);
            end else begin
                j   = k - 1 - sc;
                s   = j / sc;
                rnd = s / 4 + 1;
                v[9:6] = 4'(rnd);
                if (j % sc == 0) begin
                    case (s % 4)
                        0: v[3] = 1'b1;
                        1: v[2] = 1'b1;
                        2: if (rnd == nr) v[0] = 1'b1; else v[1] = 1'b1;
                        default: v[4] = 1'b1;
                    endcase
                end
            end
        end else if (k == len) begin
            v[11]  = 1'b1;
            v[10]  = 1'b1;
            v[9:6] = 4'(nr);
        end
        return v;
    endfunction

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    task automatic follow(input int sel, input int nr, input int sc, input int k_from,
                          input int exp_done, input int exp_mix,
                          input int r1, input int r2, input int r3);
        int          len, n_mix, n_byp, n_done, done_k;
        logic [11:0] o;
        len = 1 + sc * (1 + 4 * nr);
        n_mix = 0; n_byp = 0; n_done = 0; done_k = -1;
        for (int k = k_from; k <= len + 1; k++) begin
            step();
`ifdef AES_ROUND_CTRL_ABORT_EN
            abort_a = 1'b0;
`endif
            o = obs(sel);
            chk($sformatf("u%0d_k%0d", sel, k), 32'(o), 32'(exp_vec(nr, sc, k)));
            if (k == 1) chk($sformatf("other_idle_u%0d", 1 - sel), 32'(obs(1 - sel)), 32'd0);
            n_mix += int'(o[1]);
            n_byp += int'(o[0]);
            if (o[10]) begin
                n_done++;
                if (done_k < 0) begin
                    done_k        = k;
                    last_done_cyc = cyc;
                end
            end
            drive_start(sel, (k == r1) || (k == r2) || (k == r3));
        end
        chk($sformatf("u%0d_done_cycle", sel), 32'(done_k), 32'(exp_done));
        chk($sformatf("u%0d_done_count", sel), 32'(n_done), 32'd1);
        chk($sformatf("u%0d_mix_count", sel), 32'(n_mix), 32'(exp_mix));
        chk($sformatf("u%0d_bypass_count", sel), 32'(n_byp), 32'd1);
    endtask

    task automatic run_op(input int sel, input int nr, input int sc, input int exp_done,
                          input int exp_mix, input int r1, input int r2, input int r3);
        drive_start(sel, 1'b1);
        follow(sel, nr, sc, 1, exp_done, exp_mix, r1, r2, r3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; last_done_cyc = 0;
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort_a = 1'b0; abort_b = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rst_a_%0d", i), 32'(obs(0)), 32'd0);
            chk($sformatf("rst_b_%0d", i), 32'(obs(1)), 32'd0);
        end
        // Release reset: A sees start low, B keeps start high and launches.
        rst = 1'b0; start_a = 1'b0;
        run_op(1, 14, 3, 172, 13, -1, -1, -1);

        run_op(0, 10, 1, 42, 9, -1, -1, -1);

        // Starts during busy and during DONE are dropped; next start at cycle 43.
        t0 = cyc;
        run_op(0, 10, 1, 42, 9, 5, 20, 42);
        run_op(0, 10, 1, 42, 9, -1, -1, -1);
        chk("b2b_done_cycle", 32'(last_done_cyc - t0), 32'd85);

        // Reset while round 5 is in SHIFT.
        drive_start(0, 1'b1);
        for (int k = 1; k <= 19; k++) begin
            step();
            drive_start(0, 1'b0);
            if (k == 19) chk("midrst_pre", 32'(obs(0)), 32'(exp_vec(10, 1, 19)));
        end
        rst = 1'b1;
        step();
        chk("midrst_clear", 32'(obs(0)), 32'd0);
        rst = 1'b0;
        nz = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (obs(0) != 12'd0) nz++;
        end
        chk("midrst_no_done", 32'(nz), 32'd0);
        run_op(0, 10, 1, 42, 9, -1, -1, -1);

`ifdef AES_ROUND_CTRL_ABORT_EN
        drive_start(0, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            step();
            drive_start(0, 1'b0);
        end
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("abort_clear", 32'(obs(0)), 32'd0);
        nz = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (obs(0) != 12'd0) nz++;
        end
        chk("abort_no_done", 32'(nz), 32'd0);
        // Abort and start together in IDLE: start wins.
        abort_a = 1'b1;
        drive_start(0, 1'b1);
        follow(0, 10, 1, 1, 42, 9, -1, -1, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
